// File: rtl/writeback_checker.sv
// Writeback checker: compares in-order register-file writes against a programmed
// table of expected {register, value} pairs, with a watchdog for hung pipelines.
module writeback_checker #(
    parameter int unsigned DATA_WIDTH     = 64,
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned DEPTH          = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter bit          STOP_ON_FIRST  = 1'b1,
    parameter bit          IGNORE_XZR     = 1'b1,
    localparam int unsigned IW = $clog2(DEPTH + 1),
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic [IW-1:0]             exp_count,
    input  logic                      exp_we,
    input  logic [AW-1:0]             exp_addr,
    input  logic [REG_ADDR_WIDTH-1:0] exp_reg,
    input  logic [DATA_WIDTH-1:0]     exp_data,
    input  logic                      wb_en,
    input  logic [REG_ADDR_WIDTH-1:0] wb_reg,
    input  logic [DATA_WIDTH-1:0]     wb_data,
    output logic                      done,
    output logic                      pass,
    output logic                      fail,
    output logic                      timeout,
    output logic [IW-1:0]             check_index,
    output logic [IW-1:0]             error_count,
    output logic [IW-1:0]             first_mm_index,
    output logic [REG_ADDR_WIDTH-1:0] first_mm_reg,
    output logic [DATA_WIDTH-1:0]     first_mm_data
);

    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PASS,
        S_FAIL
    } state_e;

    state_e                    state_q;
    logic                      done_q, pass_q, fail_q, timeout_q;
    logic [IW-1:0]             count_q, idx_q, err_q, first_idx_q;
    logic [REG_ADDR_WIDTH-1:0] first_reg_q;
    logic [DATA_WIDTH-1:0]     first_data_q;
    logic [TW-1:0]             wd_q;

    logic [REG_ADDR_WIDTH-1:0] tbl_reg_q  [DEPTH];
    logic [DATA_WIDTH-1:0]     tbl_data_q [DEPTH];

    logic          accept_c;
    logic          match_c;
    logic [AW-1:0] rd_addr_c;
    logic [IW-1:0] idx_inc_c, err_inc_c, count_clamp_c;

    assign accept_c  = (state_q == S_RUN) && wb_en &&
                       !(IGNORE_XZR && (wb_reg == REG_ADDR_WIDTH'(31)));
    assign rd_addr_c = AW'(idx_q);
    assign match_c   = (tbl_reg_q[rd_addr_c] == wb_reg) && (tbl_data_q[rd_addr_c] == wb_data);

    // Saturating increments and count clamp so nothing can wrap past DEPTH
    assign idx_inc_c     = (idx_q >= IW'(DEPTH)) ? idx_q : idx_q + IW'(1);
    assign err_inc_c     = (err_q >= IW'(DEPTH)) ? err_q : err_q + IW'(1);
    assign count_clamp_c = (exp_count > IW'(DEPTH)) ? IW'(DEPTH) : exp_count;

    // Expected table: not reset, writable only outside RUN
    always_ff @(posedge clock) begin
        if (exp_we && (state_q != S_RUN)) begin
            tbl_reg_q[exp_addr]  <= exp_reg;
            tbl_data_q[exp_addr] <= exp_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_q       <= 1'b0;
            timeout_q    <= 1'b0;
            count_q      <= '0;
            idx_q        <= '0;
            err_q        <= '0;
            first_idx_q  <= '0;
            first_reg_q  <= '0;
            first_data_q <= '0;
            wd_q         <= '0;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (count_q == '0) begin
                        state_q <= S_PASS;
                        done_q  <= 1'b1;
                        pass_q  <= 1'b1;
                    end else if (accept_c) begin
                        wd_q  <= '0;
                        idx_q <= idx_inc_c;
                        if (!match_c) begin
                            err_q <= err_inc_c;
                            if (err_q == '0) begin
                                first_idx_q  <= idx_q;
                                first_reg_q  <= wb_reg;
                                first_data_q <= wb_data;
                            end
                        end
                        if (!match_c && STOP_ON_FIRST) begin
                            state_q <= S_FAIL;
                            done_q  <= 1'b1;
                            fail_q  <= 1'b1;
                        end else if (idx_inc_c == count_q) begin
                            done_q <= 1'b1;
                            if (match_c && (err_q == '0)) begin
                                state_q <= S_PASS;
                                pass_q  <= 1'b1;
                            end else begin
                                state_q <= S_FAIL;
                                fail_q  <= 1'b1;
                            end
                        end
                    end else if (wd_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        state_q   <= S_FAIL;
                        done_q    <= 1'b1;
                        fail_q    <= 1'b1;
                        timeout_q <= 1'b1;
                    end else begin
                        wd_q <= wd_q + TW'(1);
                    end
                end
                default: begin
                    // IDLE, PASS and FAIL all hold until re-armed
                    if (start) begin
                        state_q      <= S_RUN;
                        done_q       <= 1'b0;
                        pass_q       <= 1'b0;
                        fail_q       <= 1'b0;
                        timeout_q    <= 1'b0;
                        count_q      <= count_clamp_c;
                        idx_q        <= '0;
                        err_q        <= '0;
                        first_idx_q  <= '0;
                        first_reg_q  <= '0;
                        first_data_q <= '0;
                        wd_q         <= '0;
                    end
                end
            endcase
        end
    end

    assign done           = done_q;
    assign pass           = pass_q;
    assign fail           = fail_q;
    assign timeout        = timeout_q;
    assign check_index    = idx_q;
    assign error_count    = err_q;
    assign first_mm_index = first_idx_q;
    assign first_mm_reg   = first_reg_q;
    assign first_mm_data  = first_data_q;

endmodule

// File: doc/writeback_checker.md
Name: writeback_checker

Overview:
Synthesizable self-checking monitor for the pipelined ARMv8 core. It replaces hand-read $monitor dumps with an automatic pass/fail verdict. It taps the register-file writeback port and compares each architectural write, in order, against a programmed table of expected {register, value} pairs. A watchdog flags a hung pipeline. It sits beside the processor in benches and FPGA bring-up builds.

Parameters:
DATA_WIDTH, 64, width of register write data
REG_ADDR_WIDTH, 5, register index width
DEPTH, 16, number of expected-table entries
TIMEOUT_CYCLES, 1000, RUN cycles allowed without an accepted writeback before failing
STOP_ON_FIRST, 1, 1 = go to FAIL on the first mismatch; 0 = run to completion while counting errors
IGNORE_XZR, 1, 1 = writes to register 31 are neither compared nor counted

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high
start  input  1  arm or re-arm the check; accepted in IDLE, PASS and FAIL
exp_count  input  IW  number of valid table entries; IW = clog2(DEPTH+1)
exp_we  input  1  table write strobe
exp_addr  input  clog2(DEPTH)  table write index
exp_reg  input  REG_ADDR_WIDTH  expected destination register
exp_data  input  DATA_WIDTH  expected write value
wb_en  input  1  register-file write enable (RegWrite at writeback)
wb_reg  input  REG_ADDR_WIDTH  writeback destination
wb_data  input  DATA_WIDTH  writeback value
done  output  1  state is PASS or FAIL
pass  output  1  state is PASS
fail  output  1  state is FAIL
timeout  output  1  FAIL was caused by the watchdog
check_index  output  IW  entries consumed so far
error_count  output  IW  mismatches so far
first_mm_index  output  IW  table index of the first mismatch
first_mm_reg  output  REG_ADDR_WIDTH  actual register at the first mismatch
first_mm_data  output  DATA_WIDTH  actual data at the first mismatch

Behaviour:
- Reset (async, any state, including mid-RUN): state = IDLE; every output and internal counter = 0. The expected table is not cleared.
- States: IDLE, RUN, PASS, FAIL. All outputs are registered.
- Table writes are performed only in IDLE, PASS or FAIL. exp_we during RUN is ignored.
- start (IDLE/PASS/FAIL) → RUN on the next edge. On that edge:
  - latch exp_count, clamped to DEPTH;
  - clear check_index, error_count, first_mm_*, timeout and the watchdog timer.
- start during RUN is ignored.
- If the latched count is 0, the block goes RUN → PASS on the first RUN cycle.
- Accepted writeback: wb_en = 1 in RUN, and not (IGNORE_XZR and wb_reg = 31).
- On each accepted writeback, compare against entry[check_index]:
  - Match (reg and data both equal): check_index += 1.
  - Mismatch: error_count += 1 and check_index += 1. If error_count was 0, capture first_mm_index/reg/data (sticky until the next start). If STOP_ON_FIRST = 1, go to FAIL on the same edge.
- When check_index reaches the count: go to PASS if error_count = 0, otherwise FAIL. Accepted writebacks arriving later are not examined.
- Comparison latency is 1 cycle: the verdict and counters update on the edge that samples the writeback.
- Watchdog:
  - counts RUN cycles and clears on every accepted writeback;
  - on reaching TIMEOUT_CYCLES − 1 with no accepted writeback that cycle: state = FAIL and timeout = 1.
  - If a writeback and expiry occur in the same cycle, the writeback wins and the timer clears.
- PASS and FAIL hold indefinitely and ignore wb_*. Only start or reset leaves them.
- Counters saturate at DEPTH and cannot wrap.

Test Plan:
- R-type sequence: X16 = 20, X18 = 6. Table (count 7) X2 = 26, 14, 4, 22, 18, 160, 2; the core runs ADD/SUB/AND/ORR/EOR/LSL/LSR → pass = 1, check_index = 7, error_count = 0, timeout = 0.
- Corrupted entry: table entry 2 = 5 instead of 4, STOP_ON_FIRST = 1 → fail one cycle after the AND writeback; first_mm_index = 2, first_mm_reg = 2, first_mm_data = 4, error_count = 1.
- Same corruption with STOP_ON_FIRST = 0 and entry 5 = 161 → FAIL only after the 7th writeback; error_count = 2, first_mm_index = 2.
- Watchdog: TIMEOUT_CYCLES = 8, count 3, only 2 writebacks driven → fail = 1, timeout = 1, check_index = 2, exactly 8 cycles after the last writeback. Writeback on the expiry cycle → no FAIL.
- XZR and idle: interleaved wb_en with wb_reg = 31 do not advance check_index. start with exp_count = 0 → PASS the cycle after entering RUN. exp_we during RUN leaves the table unchanged.
- Reset mid-RUN at check_index = 3 → all outputs 0 immediately and state IDLE. A subsequent start with the same table passes.
